vga_pattern_gen: RTL

Pixel-stage test-pattern generator sitting directly downstream of `vgactrl` on the Nexys2 board. It consumes `hcount`, `vcount`, `hs` and `vs` and produces 8-bit RGB332 pixel data, plus sync outputs delayed to stay aligned with that data. Four selectable patterns support bring-up of the VGA path and the DCM-derived pixel timing. Pattern and resolution changes are applied only at frame boundaries, so no frame is ever torn.

---
 rtl/vga_pattern_gen.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/vga_pattern_gen.sv
// Test-pattern generator: RGB332 pixels from hcount/vcount, with syncs delayed to match.
// Latency 2 pix_en strobes; no backpressure, all state holds while pix_en is low.
module vga_pattern_gen #(
    parameter int BOX_SIZE = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hs_in,
    input  logic        vs_in,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        resolution,
    input  logic        next_pat,
    output logic        hs_out,
    output logic        vs_out,
    output logic [7:0]  rgb,
    output logic [1:0]  pattern,
    output logic [7:0]  frame_count
);

    localparam logic [10:0] BOX  = 11'(BOX_SIZE);
    localparam logic [10:0] HALF = 11'(BOX_SIZE / 2);

    logic        vs_prev;
    logic        res_q;
    logic        pending;
    logic        frame_start;

    logic [10:0] h_act;
    logic [10:0] v_act;
    logic [10:0] bar_w;
    logic [10:0] thr;
    logic [2:0]  bar_idx;
    logic        active;
    logic        check_bit;
    logic [2:0]  grad_r;
    logic [7:0]  grad;
    logic        border;
    logic [10:0] box_x2;
    logic [10:0] box_hlim;
    logic [10:0] box_x;
    logic [10:0] box_y;
    logic        in_box;

    logic        s1_active;
    logic [1:0]  s1_pat;
    logic [2:0]  s1_bar;
    logic        s1_check;
    logic [7:0]  s1_grad;
    logic        s1_border;
    logic        s1_box;
    logic        s1_hs;
    logic        s1_vs;
    logic [7:0]  colour;

    assign frame_start = pix_en & vs_prev & ~vs_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vs_prev <= 1'b1;
        end else if (pix_en) begin
            vs_prev <= vs_in;
        end
    end

    // Mode changes land only on the vsync fall, so a frame is never torn.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_count <= 8'd0;
            res_q       <= 1'b0;
            pattern     <= 2'd0;
        end else if (frame_start) begin
            frame_count <= frame_count + 8'd1;
            res_q       <= resolution;
            if (pending) begin
                pattern <= pattern + 2'd1;
            end
        end
    end

    // A request coinciding with the boundary wins, so it is kept for the next frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= 1'b0;
        end else if (next_pat) begin
            pending <= 1'b1;
        end else if (frame_start) begin
            pending <= 1'b0;
        end
    end

    assign h_act = res_q ? 11'd800 : 11'd640;
    assign v_act = res_q ? 11'd600 : 11'd480;
    assign bar_w = res_q ? 11'd100 : 11'd80;

    assign active = (hcount < h_act) && (vcount < v_act);

    always_comb begin
        bar_idx = 3'd0;
        thr     = bar_w;
        for (int i = 1; i < 8; i++) begin
            if (hcount >= thr) begin
                bar_idx = 3'(i);
            end
            thr = thr + bar_w;
        end
    end

    assign check_bit = hcount[5] ^ vcount[5];

    assign grad_r = hcount[7:5] + frame_count[2:0];
    assign grad   = {grad_r, vcount[7:5], frame_count[4:3]};

    assign border = (hcount == 11'd0) || (hcount == h_act - 11'd1) ||
                    (vcount == 11'd0) || (vcount == v_act - 11'd1);

    // frame_count*2 never exceeds 510, so one conditional subtract is a full modulo.
    assign box_x2   = {2'b00, frame_count, 1'b0};
    assign box_hlim = h_act - BOX;
    assign box_x    = (box_x2 >= box_hlim) ? (box_x2 - box_hlim) : box_x2;
    assign box_y    = (v_act >> 1) - HALF;
    assign in_box   = (hcount >= box_x) && (hcount < box_x + BOX) &&
                      (vcount >= box_y) && (vcount < box_y + BOX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_active <= 1'b0;
            s1_pat    <= 2'd0;
            s1_bar    <= 3'd0;
            s1_check  <= 1'b0;
            s1_grad   <= 8'h00;
            s1_border <= 1'b0;
            s1_box    <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else if (pix_en) begin
            s1_active <= active;
            s1_pat    <= pattern;
            s1_bar    <= bar_idx;
            s1_check  <= check_bit;
            s1_grad   <= grad;
            s1_border <= border;
            s1_box    <= in_box;
            s1_hs     <= hs_in;
            s1_vs     <= vs_in;
        end
    end

    always_comb begin
        colour = 8'h00;
        unique case (s1_pat)
            2'd0: begin
                unique case (s1_bar)
                    3'd0:    colour = 8'hFF;
                    3'd1:    colour = 8'hFC;
                    3'd2:    colour = 8'h1F;
                    3'd3:    colour = 8'h1C;
                    3'd4:    colour = 8'hE3;
                    3'd5:    colour = 8'hE0;
                    3'd6:    colour = 8'h03;
                    default: colour = 8'h00;
                endcase
            end
            2'd1:    colour = s1_check ? 8'hFF : 8'h00;
            2'd2:    colour = s1_grad;
            default: colour = s1_border ? 8'hFF : (s1_box ? 8'hE0 : 8'h00);
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rgb    <= 8'h00;
            hs_out <= 1'b1;
            vs_out <= 1'b1;
        end else if (pix_en) begin
            rgb    <= s1_active ? colour : 8'h00;
            hs_out <= s1_hs;
            vs_out <= s1_vs;
        end
    end

endmodule
